mem_line_bridge: RTL and testbench
==================================

# mem_line_bridge

Bridge between the CPU's 256-bit data-memory port and a 32-bit-wide synchronous SRAM. It sits directly downstream of the CPU/dcache memory interface (enable, write, address, 256-bit line, ack). Each cache-line request becomes 8 sequential single-word SRAM beats. A one-cycle ack pulse is returned when the line has been written or the full read line is available.

## Interface

Parameters:
- ADDR_W, 14, SRAM word-address width (2^ADDR_W 32-bit words).
- WAIT_CYCLES, 0, idle cycles inserted between request acceptance and the first beat (models slow memory); range 0..15.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- mem_enable_i  input  1  request valid from dcache.
- mem_write_i  input  1  1 = line write, 0 = line read.
- mem_addr_i  input  32  byte address; bits [4:0] ignored.
- mem_data_i  input  256  write line; word k = bits [32k+31:32k].
- mem_data_o  output  256  read line, valid when mem_ack_o=1 for a read; holds until the next read completes.
- mem_ack_o  output  1  one-cycle completion pulse.
- sram_en_o  output  1  SRAM access strobe.
- sram_we_o  output  1  SRAM write strobe (only with sram_en_o).
- sram_addr_o  output  ADDR_W  SRAM word address.
- sram_wdata_o  output  32  SRAM write word.
- sram_rdata_i  input  32  SRAM read word, valid the cycle after a read strobe.

## Operation

- States: IDLE, WAIT, WBEAT, RBEAT, RLAST, DONE.
- IDLE: if mem_enable_i=1, latch mem_write_i, mem_data_i, and base = mem_addr_i[ADDR_W+1:5]. Clear beat counter. Go to WAIT if WAIT_CYCLES>0, else WBEAT (write) or RBEAT (read).
- WAIT: counts WAIT_CYCLES cycles, then goes to WBEAT or RBEAT.
- WBEAT beat k (0..7):
  - sram_en_o=1, sram_we_o=1.
  - sram_addr_o = {base, k[2:0]}; sram_wdata_o = latched word k.
  - After k=7, go to DONE.
- RBEAT beat k (0..7):
  - sram_en_o=1, sram_we_o=0, sram_addr_o = {base, k}.
  - In beats k≥1, capture sram_rdata_i into line word k-1.
  - After k=7, go to RLAST.
- RLAST: sram_en_o=0; capture word 7; go to DONE.
- DONE: mem_ack_o=1 for exactly one cycle.
  - For a read, mem_data_o is updated from the assembled line by this cycle.
  - Next state is IDLE.
- Request inputs are ignored outside IDLE. Deasserting mem_enable_i or changing addr/data mid-transaction has no effect; the latched transaction completes.
- Back-to-back requests: enable held high through the ack cycle with new addr/write is accepted as a new request in the IDLE cycle that follows. This supports writeback immediately followed by a refill.
- mem_data_o is unchanged by write transactions.
- Address bits above ADDR_W+1 are ignored (aliasing).
- All sram_* outputs and mem_ack_o are driven from registers only; there is no combinational path from any input.
- When not in a beat state: sram_en_o=0, sram_we_o=0; sram_addr_o and sram_wdata_o hold their last values.

## Timing

- Request sampled at the end of IDLE cycle N.
- Write: beats occupy cycles N+1+W .. N+8+W, where W = WAIT_CYCLES. mem_ack_o=1 in cycle N+9+W.
- Read: strobes occupy cycles N+1+W .. N+8+W. Word 7 is captured at the end of N+9+W (RLAST). mem_ack_o=1 and mem_data_o valid in cycle N+10+W.
- Minimum request-to-request spacing: 10+W cycles for a write, 11+W for a read (including the IDLE cycle).
- Reset (rst_i=0, asynchronous) forces all of the following immediately:
  - state=IDLE, counters=0.
  - mem_ack_o=0, mem_data_o=0.
  - sram_en_o=0, sram_we_o=0, sram_addr_o=0, sram_wdata_o=0.
- Reset mid-transaction aborts it with no ack. SRAM words already written stay written.
- The first request after reset release is accepted in the first IDLE cycle with rst_i=1.

## Test plan

- Write line 0x...0007_0006_..._0000 (word k = k) at addr 0x0000_0040, W=0. Required: sram writes to word addresses 16..23 with data 0..7 in cycles N+1..N+8; single ack at N+9.
- Read the same addr 0x0000_0040 (W=0). Required: ack at N+10; mem_data_o word k = k; no ack in any other cycle.
- Back-to-back: write to 0x80, keep enable=1, switch to a read of 0x40 in the ack cycle. Required: read accepted in the next IDLE cycle; second ack exactly 11 cycles after the first; mem_data_o correct.
- Mid-transaction chaos: drop enable and change addr/data in the cycle after acceptance. Required: original transaction completes unchanged with its ack.
- Reset in write beat 3. Required: all outputs 0 immediately, no ack; SRAM words base+0..base+2 hold the new data and base+3..7 hold the old data.
- WAIT_CYCLES=3: read of 0x0000_01E3. Required: base word address 120 (low 5 address bits ignored); first strobe at N+4; ack at N+13.

Source files
------------

// File: rtl/mem_line_bridge_if.sv
// Bundle of the dcache line port and the 32-bit SRAM port seen by mem_line_bridge.
// slave = the bridge; master = the dcache plus SRAM side that surrounds it.
interface mem_line_bridge_if #(
  parameter int ADDR_W = 14
);
  logic               mem_enable_i;
  logic               mem_write_i;
  logic [31:0]        mem_addr_i;
  logic [255:0]       mem_data_i;
  logic [255:0]       mem_data_o;
  logic               mem_ack_o;
  logic               sram_en_o;
  logic               sram_we_o;
  logic [ADDR_W-1:0]  sram_addr_o;
  logic [31:0]        sram_wdata_o;
  logic [31:0]        sram_rdata_i;

  modport slave (
    input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i, sram_rdata_i,
    output mem_data_o, mem_ack_o, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i, sram_rdata_i,
    input  mem_data_o, mem_ack_o, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/mem_line_bridge.sv
// Splits each 256-bit cache-line request into eight sequential 32-bit SRAM
// beats and returns a one-cycle ack once the line is written or assembled.
module mem_line_bridge #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_line_bridge_if.slave bus
);
  localparam int BASE_W = ADDR_W - 3;
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WBEAT, S_RBEAT, S_RLAST, S_DONE
  } state_t;

  state_t             state;
  logic [2:0]         beat;
  logic [3:0]         wait_cnt;
  logic               is_write;
  logic [255:0]       wline;
  logic [223:0]       rline;
  logic [BASE_W-1:0]  base;
  logic [255:0]       mem_data_q;
  logic               ack_q;
  logic               en_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;

  logic [2:0]         beat_nx;
  logic [2:0]         beat_pv;
  logic [BASE_W-1:0]  req_base;
  logic               unused_addr;

  assign beat_nx     = beat + 3'd1;
  assign beat_pv     = beat - 3'd1;
  assign req_base    = bus.mem_addr_i[ADDR_W+1:5];
  assign unused_addr = ^{bus.mem_addr_i[31:ADDR_W+2], bus.mem_addr_i[4:0]};

  // Every SRAM strobe is registered one cycle ahead: the state that precedes
  // a beat loads the address/data so the beat appears on the next clock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      beat       <= '0;
      wait_cnt   <= '0;
      is_write   <= 1'b0;
      wline      <= '0;
      rline      <= '0;
      base       <= '0;
      mem_data_q <= '0;
      ack_q      <= 1'b0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      en_q  <= 1'b0;
      we_q  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.mem_enable_i) begin
            is_write <= bus.mem_write_i;
            wline    <= bus.mem_data_i;
            base     <= req_base;
            beat     <= '0;
            wait_cnt <= '0;
            if (WAIT_CYCLES > 0) begin
              state <= S_WAIT;
            end else begin
              state  <= bus.mem_write_i ? S_WBEAT : S_RBEAT;
              en_q   <= 1'b1;
              we_q   <= bus.mem_write_i;
              addr_q <= {req_base, 3'd0};
              if (bus.mem_write_i) wdata_q <= bus.mem_data_i[31:0];
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state  <= is_write ? S_WBEAT : S_RBEAT;
            en_q   <= 1'b1;
            we_q   <= is_write;
            addr_q <= {base, 3'd0};
            if (is_write) wdata_q <= wline[31:0];
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_WBEAT: begin
          if (beat == 3'd7) begin
            state <= S_DONE;
            ack_q <= 1'b1;
          end else begin
            beat    <= beat_nx;
            en_q    <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= {base, beat_nx};
            wdata_q <= wline[{beat_nx, 5'd0} +: 32];
          end
        end
        S_RBEAT: begin
          // Read data lags its strobe by one cycle, so beat k stores word k-1.
          if (beat != 3'd0) rline[{beat_pv, 5'd0} +: 32] <= bus.sram_rdata_i;
          if (beat == 3'd7) begin
            state <= S_RLAST;
          end else begin
            beat   <= beat_nx;
            en_q   <= 1'b1;
            addr_q <= {base, beat_nx};
          end
        end
        S_RLAST: begin
          mem_data_q <= {bus.sram_rdata_i, rline};
          ack_q      <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_data_o   = mem_data_q;
  assign bus.mem_ack_o    = ack_q;
  assign bus.sram_en_o    = en_q;
  assign bus.sram_we_o    = we_q;
  assign bus.sram_addr_o  = addr_q;
  assign bus.sram_wdata_o = wdata_q;
endmodule

// File: tb/tb_mem_line_bridge.sv
// Randomised scoreboard bench for mem_line_bridge: one instance with no wait
// cycles, one with three, each backed by a behavioural SRAM and line model.
module tb_mem_line_bridge;
  localparam int AW = 14;
  localparam int W1 = 3;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  mem_line_bridge_if #(.ADDR_W(AW)) b0 ();
  mem_line_bridge_if #(.ADDR_W(AW)) b1 ();

  mem_line_bridge #(.ADDR_W(AW), .WAIT_CYCLES(0))  dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(b0));
  mem_line_bridge #(.ADDR_W(AW), .WAIT_CYCLES(W1)) dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(b1));

  typedef struct packed {
    int unsigned   cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } beat_t;

  typedef struct packed {
    int unsigned  cyc;
    logic [255:0] data;
  } ack_t;

  beat_t bq0[$];
  beat_t bq1[$];
  ack_t  aq0[$];
  ack_t  aq1[$];

  int unsigned  cyc = 0;
  int unsigned  n_chk = 0;
  int unsigned  n_pass = 0;
  int unsigned  ready [2];
  logic [255:0] last_rd [2];
  logic [31:0]  model [2][1<<AW];
  logic [31:0]  sram0 [1<<AW];
  logic [31:0]  sram1 [1<<AW];
  logic [AW-4:0] pool0 [8];
  logic [AW-4:0] pool1 [8];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Synchronous SRAMs: read data appears the cycle after the strobe.
  always @(posedge clk_i) begin
    if (b0.sram_en_o) begin
      if (b0.sram_we_o) sram0[b0.sram_addr_o] <= b0.sram_wdata_o;
      else              b0.sram_rdata_i <= sram0[b0.sram_addr_o];
    end
    if (b1.sram_en_o) begin
      if (b1.sram_we_o) sram1[b1.sram_addr_o] <= b1.sram_wdata_o;
      else              b1.sram_rdata_i <= sram1[b1.sram_addr_o];
    end
  end

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endfunction

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [31:0] mk_addr(logic [AW-4:0] base);
    logic [31:0] a;
    a = $urandom;
    a[AW+1:5] = base;
    return a;
  endfunction

  // Expected SRAM beats, ack cycle and ack data for a request accepted in cycle n.
  function automatic void expect_txn(int d, int unsigned n, logic wr, logic [31:0] addr,
                                     logic [255:0] data, bit commit);
    int unsigned   w;
    logic [AW-4:0] base;
    logic [AW-1:0] wa;
    logic [255:0]  line;
    beat_t         b;
    ack_t          a;
    w    = (d == 0) ? 0 : W1;
    base = addr[AW+1:5];
    line = '0;
    for (int k = 0; k < 8; k++) begin
      wa      = {base, 3'(k)};
      b.cyc   = n + 1 + w + k;
      b.we    = wr;
      b.addr  = wa;
      b.wdata = wr ? data[32*k +: 32] : 32'd0;
      if (d == 0) bq0.push_back(b); else bq1.push_back(b);
      if (!wr) line[32*k +: 32] = model[d][wa];
      else if (commit) model[d][wa] = data[32*k +: 32];
    end
    if (!wr) last_rd[d] = line;
    a.cyc  = n + (wr ? 9 : 10) + w;
    a.data = last_rd[d];
    if (d == 0) aq0.push_back(a); else aq1.push_back(a);
    ready[d] = n + (wr ? 10 : 11) + w;
  endfunction

  function automatic void mon(int d, logic en, logic we, logic [AW-1:0] addr, logic [31:0] wd,
                              logic ack, logic [255:0] md);
    beat_t b;
    ack_t  a;
    bit    have;
    if (we) chk($sformatf("dut%0d_we_needs_en", d), en, 1'b1);
    if (en) begin
      have = (d == 0) ? (bq0.size() > 0) : (bq1.size() > 0);
      if (!have) chk($sformatf("dut%0d_unexpected_strobe", d), en, 1'b0);
      else begin
        b = (d == 0) ? bq0.pop_front() : bq1.pop_front();
        chk($sformatf("dut%0d_beat_cyc_we_addr", d), {cyc, we, addr}, {b.cyc, b.we, b.addr});
        if (b.we) chk($sformatf("dut%0d_beat_wdata", d), wd, b.wdata);
      end
    end
    if (ack) begin
      have = (d == 0) ? (aq0.size() > 0) : (aq1.size() > 0);
      if (!have) chk($sformatf("dut%0d_unexpected_ack", d), ack, 1'b0);
      else begin
        a = (d == 0) ? aq0.pop_front() : aq1.pop_front();
        chk($sformatf("dut%0d_ack_cycle", d), cyc, a.cyc);
        chk($sformatf("dut%0d_ack_line", d), md, a.data);
      end
    end
  endfunction

  always @(negedge clk_i) begin
    if (rst_i) begin
      mon(0, b0.sram_en_o, b0.sram_we_o, b0.sram_addr_o, b0.sram_wdata_o, b0.mem_ack_o, b0.mem_data_o);
      mon(1, b1.sram_en_o, b1.sram_we_o, b1.sram_addr_o, b1.sram_wdata_o, b1.mem_ack_o, b1.mem_data_o);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(int d, logic en, logic wr, logic [31:0] a, logic [255:0] dt);
    if (d == 0) begin
      b0.mem_enable_i = en; b0.mem_write_i = wr; b0.mem_addr_i = a; b0.mem_data_i = dt;
    end else begin
      b1.mem_enable_i = en; b1.mem_write_i = wr; b1.mem_addr_i = a; b1.mem_data_i = dt;
    end
  endtask

  // While the bridge is busy its request inputs get random junk (including enable).
  task automatic issue(int d, logic wr, logic [31:0] a, logic [255:0] dt, int unsigned gap, bit commit);
    while (cyc < ready[d]) begin
      drive(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, rnd_line());
      step();
    end
    for (int unsigned i = 0; i < gap; i++) begin
      drive(d, 1'b0, 1'($urandom_range(0, 1)), $urandom, rnd_line());
      step();
    end
    drive(d, 1'b1, wr, a, dt);
    expect_txn(d, cyc, wr, a, dt, commit);
    step();
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_d0_ack"},   b0.mem_ack_o,    1'b0);
    chk({tag, "_d0_line"},  b0.mem_data_o,   256'd0);
    chk({tag, "_d0_en_we"}, {b0.sram_en_o, b0.sram_we_o}, 2'b00);
    chk({tag, "_d0_addr"},  b0.sram_addr_o,  '0);
    chk({tag, "_d0_wdata"}, b0.sram_wdata_o, 32'd0);
    chk({tag, "_d1_ack"},   b1.mem_ack_o,    1'b0);
    chk({tag, "_d1_line"},  b1.mem_data_o,   256'd0);
    chk({tag, "_d1_en_we"}, {b1.sram_en_o, b1.sram_we_o}, 2'b00);
  endtask

  task automatic release_reset();
    rst_i = 1'b1;
    ready[0] = cyc;
    ready[1] = cyc;
    last_rd[0] = '0;
    last_rd[1] = '0;
  endtask

  task automatic random_mix(int d, int unsigned count);
    logic [AW-4:0] base;
    for (int unsigned i = 0; i < count; i++) begin
      base = (d == 0) ? pool0[$urandom_range(0, 7)] : pool1[$urandom_range(0, 7)];
      issue(d, 1'($urandom_range(0, 1)), mk_addr(base), rnd_line(), $urandom_range(0, 3), 1'b1);
    end
  endtask

  initial begin
    logic [255:0]  lk;
    logic [255:0]  nb;
    logic [31:0]   old_w [8];
    logic [31:0]   ra;
    int unsigned   n;
    logic [AW-1:0] wa;

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    b0.sram_rdata_i = '0;
    b1.sram_rdata_i = '0;
    ready[0] = 0;
    ready[1] = 0;
    for (int k = 0; k < 8; k++) lk[32*k +: 32] = k;
    pool0[0] = 11'd2;
    pool0[1] = 11'd4;
    pool1[0] = 11'd15;
    for (int i = 1; i < 8; i++) pool1[i] = 11'($urandom);
    for (int i = 2; i < 8; i++) pool0[i] = 11'($urandom);

    rst_i = 1'b0;
    repeat (3) step();
    check_reset_outputs("por");
    release_reset();

    // Instance 0, no wait cycles
    issue(0, 1'b1, 32'h0000_0040, lk, 0, 1'b1);
    issue(0, 1'b0, 32'h0000_0040, '0, 2, 1'b1);
    for (int i = 0; i < 8; i++) issue(0, 1'b1, mk_addr(pool0[i]), rnd_line(), $urandom_range(0, 2), 1'b1);
    issue(0, 1'b1, 32'h0000_0080, rnd_line(), 0, 1'b1);
    issue(0, 1'b0, 32'h0000_0040, '0, 0, 1'b1);
    random_mix(0, 40);

    // Reset during write beat 3: only words 0..2 of the new line reach the SRAM
    ra = mk_addr(pool0[3]);
    for (int k = 0; k < 8; k++) old_w[k] = model[0][{pool0[3], 3'(k)}];
    nb = rnd_line();
    issue(0, 1'b1, ra, nb, 1, 1'b0);
    n = ready[0] - 10;
    drive(0, 1'b0, 1'b0, '0, '0);
    while (cyc < n + 4) step();
    rst_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    bq0.delete();
    aq0.delete();
    repeat (2) step();
    for (int k = 0; k < 8; k++) begin
      wa = {pool0[3], 3'(k)};
      chk($sformatf("midrst_sram_word%0d", k), sram0[wa], (k < 3) ? nb[32*k +: 32] : old_w[k]);
      if (k < 3) model[0][wa] = nb[32*k +: 32];
    end
    release_reset();
    issue(0, 1'b0, ra, '0, 0, 1'b1);
    random_mix(0, 10);

    // Instance 1, three wait cycles
    drive(0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) issue(1, 1'b1, mk_addr(pool1[i]), rnd_line(), $urandom_range(0, 2), 1'b1);
    issue(1, 1'b0, 32'h0000_01E3, '0, 1, 1'b1);
    random_mix(1, 20);

    drive(1, 1'b0, 1'b0, '0, '0);
    while (cyc < ready[0] + 3 || cyc < ready[1] + 3) step();
    chk("d0_beats_outstanding", bq0.size(), 0);
    chk("d0_acks_outstanding",  aq0.size(), 0);
    chk("d1_beats_outstanding", bq1.size(), 0);
    chk("d1_acks_outstanding",  aq1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
